// File: rtl/systolic_tile_feeder_if.sv
// Buffer-read and systolic-array signal bundle between the tile feeder (master)
// and the global buffers / systolic array (slave).
interface systolic_tile_feeder_if #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int SYS_ARRAY_SIZE   = 4,
    parameter int K_SIZE           = 8,
    parameter int ADDR_WIDTH       = 16
);
    localparam int VEC_W = INPUT_DATA_WIDTH * SYS_ARRAY_SIZE;

    logic                      buf_ready;
    logic                      a_rd_en;
    logic [ADDR_WIDTH-1:0]     a_addr;
    logic [VEC_W-1:0]          a_rdata;
    logic                      b_rd_en;
    logic [ADDR_WIDTH-1:0]     b_addr;
    logic [VEC_W-1:0]          b_rdata;
    logic [SYS_ARRAY_SIZE-1:0] sa_in_valid;
    logic [K_SIZE-1:0]         sa_k;
    logic [VEC_W-1:0]          sa_A;
    logic [VEC_W-1:0]          sa_B;
    logic                      sa_out_valid;

    modport master (
        input  buf_ready, a_rdata, b_rdata, sa_out_valid,
        output a_rd_en, a_addr, b_rd_en, b_addr, sa_in_valid, sa_k, sa_A, sa_B
    );

    modport slave (
        output buf_ready, a_rdata, b_rdata, sa_out_valid,
        input  a_rd_en, a_addr, b_rd_en, b_addr, sa_in_valid, sa_k, sa_A, sa_B
    );
endinterface

// File: rtl/systolic_tile_feeder.sv
// Systolic tile feeder: streams A columns / B rows for a number of tiles from
// the global buffers into the array, then waits for every C row to drain.
module systolic_tile_feeder #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int SYS_ARRAY_SIZE   = 4,
    parameter int K_SIZE           = 8,
    parameter int ADDR_WIDTH       = 16,
    parameter int TILE_WIDTH       = 8,
    parameter int DRAIN_TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [K_SIZE-1:0]     k_cfg,
    input  logic [TILE_WIDTH-1:0] tiles_cfg,
    input  logic [ADDR_WIDTH-1:0] a_base,
    input  logic [ADDR_WIDTH-1:0] b_base,
    systolic_tile_feeder_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout
);
    localparam int VEC_W  = INPUT_DATA_WIDTH * SYS_ARRAY_SIZE;
    localparam int ROW_W  = TILE_WIDTH + $clog2(SYS_ARRAY_SIZE) + 1;
    localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [K_SIZE-1:0]     k_lat;
    logic [TILE_WIDTH-1:0] tiles_lat;
    logic [ADDR_WIDTH-1:0] a_base_lat, b_base_lat;
    logic [K_SIZE-1:0]     step;
    logic [TILE_WIDTH-1:0] tile;
    logic [ADDR_WIDTH-1:0] off;
    logic [ROW_W-1:0]      row_cnt, row_total;
    logic [IDLE_W-1:0]     idle_cnt;
    logic                  start_ok, cfg_empty, last_rd, rows_done, timeout_hit, rd_en;
    logic                  rd_vld_p1;
    logic [VEC_W-1:0]      sa_a_p1, sa_b_p1;

    assign start_ok    = (state == S_IDLE) && start;
    assign cfg_empty   = (k_cfg == '0) || (tiles_cfg == '0);
    // t*k+s is kept as a running offset, so addresses wrap naturally at ADDR_WIDTH
    assign last_rd     = (tile == tiles_lat - TILE_WIDTH'(1)) && (step == k_lat - K_SIZE'(1));
    assign row_total   = ROW_W'(tiles_lat) * ROW_W'(SYS_ARRAY_SIZE);
    assign rows_done   = (row_cnt == row_total);
    assign timeout_hit = (idle_cnt == IDLE_W'(DRAIN_TIMEOUT));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = cfg_empty ? S_DONE : S_FEED;
            S_FEED:  if (bus.buf_ready && last_rd) state_nxt = S_DRAIN;
            S_DRAIN: if (rows_done || timeout_hit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Per-state outputs: read strobe only while feeding with buffers ready
    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            S_FEED: begin
                rd_en = bus.buf_ready;
                busy  = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.a_rd_en     = rd_en;
    assign bus.b_rd_en     = rd_en;
    assign bus.a_addr      = rd_en ? a_base_lat + off : '0;
    assign bus.b_addr      = rd_en ? b_base_lat + off : '0;
    assign bus.sa_k        = k_lat;
    assign bus.sa_in_valid = {SYS_ARRAY_SIZE{rd_vld_p1}};
    assign bus.sa_A        = sa_a_p1;
    assign bus.sa_B        = sa_b_p1;

    // Latch the job configuration on an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_lat      <= '0;
            tiles_lat  <= '0;
            a_base_lat <= '0;
            b_base_lat <= '0;
        end else if (start_ok) begin
            k_lat      <= k_cfg;
            tiles_lat  <= tiles_cfg;
            a_base_lat <= a_base;
            b_base_lat <= b_base;
        end
    end

    // Step/tile/offset counters advance only on an issued read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step <= '0;
            tile <= '0;
            off  <= '0;
        end else if (start_ok) begin
            step <= '0;
            tile <= '0;
            off  <= '0;
        end else if (rd_en) begin
            off <= off + ADDR_WIDTH'(1);
            if (step == k_lat - K_SIZE'(1)) begin
                step <= '0;
                tile <= tile + TILE_WIDTH'(1);
            end else begin
                step <= step + K_SIZE'(1);
            end
        end
    end

    // Count drained C rows outside IDLE, and idle cycles while draining
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt  <= '0;
            idle_cnt <= '0;
        end else begin
            if (start_ok)
                row_cnt <= '0;
            else if (state != S_IDLE && bus.sa_out_valid)
                row_cnt <= row_cnt + ROW_W'(1);
            if (state != S_DRAIN || bus.sa_out_valid)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    // Sticky timeout flag, cleared when the next job is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_timeout <= 1'b0;
        else if (start_ok)
            err_timeout <= 1'b0;
        else if (state == S_DRAIN && !rows_done && timeout_hit)
            err_timeout <= 1'b1;
    end

    // p0 -> p1: read data and its valid move to the array one cycle after the strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_p1 <= 1'b0;
            sa_a_p1   <= '0;
            sa_b_p1   <= '0;
        end else begin
            rd_vld_p1 <= rd_en;
            if (rd_en) begin
                sa_a_p1 <= bus.a_rdata;
                sa_b_p1 <= bus.b_rdata;
            end
        end
    end
endmodule
